seg_scan_driver: RTL and testbench

Time-multiplexed seven-segment scan driver for the range-hood controller's 8-digit display. It holds a double-buffered frame of eight hex nibbles plus per-digit decimal-point, blank and blink masks. It scans four slots continuously, lighting one tube in each 4-digit group per slot. It is the producing end of the `digit1`/`digit2`/`tube_sel` display bus: upstream mode and time logic write frames, and the block drives the board pins.

---
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with a double-buffered frame.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] frame_data,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [31:0]   act_frame_q, act_frame_d, pend_frame_q, pend_frame_d;
    logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [7:0]    act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic          pend_q, pend_d;
    logic          load_ack_q;
    logic [7:0]    digit1_q, digit1_d, digit2_q, digit2_d, tube_sel_q, tube_sel_d;
    logic          slot_start, cnt_wrap, commit;
    logic [7:0]    act_blink_d;
    logic          blink_on;
    logic [2:0]    lo_idx, hi_idx;

    function automatic logic [7:0] encode(input logic [3:0] nib);
        case (nib)
            4'h0: encode = 8'hFC;  4'h1: encode = 8'h60;
            4'h2: encode = 8'hDA;  4'h3: encode = 8'hF2;
            4'h4: encode = 8'h66;  4'h5: encode = 8'hB6;
            4'h6: encode = 8'hBE;  4'h7: encode = 8'hE0;
            4'h8: encode = 8'hFE;  4'h9: encode = 8'hF6;
            4'hA: encode = 8'hEE;  4'hB: encode = 8'h3E;
            4'hC: encode = 8'h9C;  4'hD: encode = 8'h7A;
            4'hE: encode = 8'h9E;  default: encode = 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dp,
                                          input logic blank, input logic blink_off);
        if (blank || blink_off) seg_of = 8'h00;
        else                    seg_of = encode(nib) | {7'b0, dp};
    endfunction

    assign slot_start = (cnt_q == '0);
    assign cnt_wrap   = (cnt_q == CNT_MAX);
    assign commit     = slot_start && (slot_q == 2'd0) && pend_q;

    assign cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
    assign slot_d = cnt_wrap ? slot_q + 2'd1 : slot_q;

    // On a load that coincides with commit, the older pending data moves to
    // active while the new data lands in pending and pend stays set.
    assign act_frame_d  = commit ? pend_frame_q : act_frame_q;
    assign act_dp_d     = commit ? pend_dp_q    : act_dp_q;
    assign act_blank_d  = commit ? pend_blank_q : act_blank_q;
    assign pend_frame_d = load ? frame_data : pend_frame_q;
    assign pend_dp_d    = load ? dp_mask    : pend_dp_q;
    assign pend_blank_d = load ? blank_mask : pend_blank_q;
    assign pend_d       = load | (pend_q & ~commit);

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_on_q;
    logic [7:0]    act_blink_q, pend_blink_q;

    assign act_blink_d = commit ? pend_blink_q : act_blink_q;
    assign blink_on    = blink_on_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            act_blink_q  <= '0;
            pend_blink_q <= '0;
        end else begin
            blink_cnt_q  <= (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
            blink_on_q   <= (blink_cnt_q == BLINK_MAX) ? ~blink_on_q : blink_on_q;
            act_blink_q  <= act_blink_d;
            pend_blink_q <= load ? blink_mask : pend_blink_q;
        end
    end
`else
    logic unused_blink;

    assign act_blink_d  = '0;
    assign blink_on     = 1'b1;
    assign unused_blink = ^blink_mask ^ (BLINK_DIV > 0);
`endif

    assign lo_idx = {1'b0, slot_q};
    assign hi_idx = {1'b1, slot_q};

    // Segments come from the next active frame so new data meets load_ack.
    always_comb begin
        digit1_d   = 8'h00;
        digit2_d   = 8'h00;
        tube_sel_d = 8'h00;
        if (en) begin
            digit1_d = seg_of(act_frame_d[{lo_idx, 2'b00} +: 4], act_dp_d[lo_idx],
                              act_blank_d[lo_idx], act_blink_d[lo_idx] & ~blink_on);
            digit2_d = seg_of(act_frame_d[{hi_idx, 2'b00} +: 4], act_dp_d[hi_idx],
                              act_blank_d[hi_idx], act_blink_d[hi_idx] & ~blink_on);
            if (!slot_start) tube_sel_d = 8'h11 << slot_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the frame buffers are plain registers, not a RAM, so they
            // are reset; a pending frame must not survive reset.
            cnt_q        <= '0;
            slot_q       <= 2'd0;
            act_frame_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_frame_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_q       <= 1'b0;
            load_ack_q   <= 1'b0;
            digit1_q     <= '0;
            digit2_q     <= '0;
            tube_sel_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge state, independent of statement order.
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            act_frame_q  <= act_frame_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_frame_q <= pend_frame_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_q       <= pend_d;
            load_ack_q   <= commit;
            digit1_q     <= digit1_d;
            digit2_q     <= digit2_d;
            tube_sel_q   <= tube_sel_d;
        end
    end

    assign load_ack = load_ack_q;
    assign digit1   = digit1_q;
    assign digit2   = digit2_q;
    assign tube_sel = tube_sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (SCAN_DIV=4, BLINK_DIV=16).
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] frame_data;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic        load;
    logic        load_ack;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;

    int tests = 0;
    int fails = 0;
    int edges;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame_data (frame_data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .load       (load),
        .load_ack   (load_ack),
        .digit1     (digit1),
        .digit2     (digit2),
        .tube_sel   (tube_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last reset release, used to predict the blink phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] f, input logic [7:0] dp, input logic [7:0] bl,
                         input logic [7:0] bk);
        frame_data = f;
        dp_mask    = dp;
        blank_mask = bl;
        blink_mask = bk;
    endtask

    task automatic pulse_load(input logic [31:0] f, input logic [7:0] dp,
                              input logic [7:0] bl, input logic [7:0] bk);
        drive(f, dp, bl, bk);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (load_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_ack_seen"}, {31'b0, got}, 32'd1);
    endtask

    // Cycle j counts from the load_ack cycle; e1/e2 hold the slot 0..3 bytes.
    task automatic check_frame(input int start, input logic [31:0] e1, input logic [31:0] e2,
                               input string tag);
        int         s;
        logic [7:0] et;
        for (int j = start; j < 16; j++) begin
            s  = j / 4;
            et = (j % 4 == 0) ? 8'h00 : (8'h11 << s);
            check($sformatf("%s_j%0d_tube", tag, j), {24'b0, tube_sel}, {24'b0, et});
            check($sformatf("%s_j%0d_d1", tag, j), {24'b0, digit1}, {24'b0, e1[8*s +: 8]});
            check($sformatf("%s_j%0d_d2", tag, j), {24'b0, digit2}, {24'b0, e2[8*s +: 8]});
            check($sformatf("%s_j%0d_ack", tag, j), {31'b0, load_ack}, (j == 0) ? 32'd1 : 32'd0);
            if (j < 15) tick();
        end
    endtask

    initial begin
        int         s;
        int         c;
        logic       on;
        logic [7:0] et;
        logic [7:0] e1b;
        logic [31:0] e1;

        rst  = 1'b0;
        en   = 1'b1;
        load = 1'b0;
        drive(32'h0, 8'h00, 8'h00, 8'h00);

        // Reset state and first two cycles after release
        repeat (3) tick();
        check("rst_tube", {24'b0, tube_sel}, 32'h00);
        check("rst_d1", {24'b0, digit1}, 32'h00);
        check("rst_d2", {24'b0, digit2}, 32'h00);
        check("rst_ack", {31'b0, load_ack}, 32'd0);
        rst = 1'b1;
        tick();
        check("first_edge_tube", {24'b0, tube_sel}, 32'h00);
        tick();
        check("second_edge_tube", {24'b0, tube_sel}, 32'h11);
        check("second_edge_d1", {24'b0, digit1}, 32'hFC);
        check("second_edge_d2", {24'b0, digit2}, 32'hFC);

        // Basic frame
        pulse_load(32'h76543210, 8'h00, 8'h00, 8'h00);
        wait_ack("basic");
        check_frame(0, 32'hF2DA60FC, 32'hE0BEB666, "basic");

        // Two loads within one frame: last write wins, one ack
        pulse_load(32'hFEDCBA98, 8'h00, 8'h00, 8'h00);
        tick();
        pulse_load(32'h11111111, 8'h00, 8'h00, 8'h00);
        wait_ack("dbl");
        check_frame(0, 32'h60606060, 32'h60606060, "dbl");

        // Decimal point on digit 0, blank on digit 7
        pulse_load(32'h88888888, 8'h01, 8'h80, 8'h00);
        wait_ack("dpblank");
        check_frame(0, 32'hFEFEFEFF, 32'h00FEFEFE, "dpblank");

        // Load in the last cycle of slot 3: ack one cycle later
        repeat (15) tick();
        pulse_load(32'hEDCBA987, 8'h00, 8'h00, 8'h00);
        tick();
        check("minlat_ack", {31'b0, load_ack}, 32'd1);
        check_frame(0, 32'hEEF6FEE0, 32'h9E7A9C3E, "minlat");

        // Load coinciding with commit: older data commits, newer stays pending
        pulse_load(32'h33333333, 8'h00, 8'h00, 8'h00);
        repeat (15) tick();
        pulse_load(32'h44444444, 8'h00, 8'h00, 8'h00);
        check_frame(0, 32'hF2F2F2F2, 32'hF2F2F2F2, "coll_old");
        tick();
        check_frame(0, 32'h66666666, 32'h66666666, "coll_new");

        // Display disable mid-frame, load while disabled, resume
        repeat (5) tick();
        en = 1'b0;
        tick();
        check("en0_tube", {24'b0, tube_sel}, 32'h00);
        check("en0_d1", {24'b0, digit1}, 32'h00);
        check("en0_d2", {24'b0, digit2}, 32'h00);
        pulse_load(32'h55555555, 8'h00, 8'h00, 8'h00);
        wait_ack("en0");
        check("en0_ack_tube", {24'b0, tube_sel}, 32'h00);
        check("en0_ack_d1", {24'b0, digit1}, 32'h00);
        check("en0_ack_d2", {24'b0, digit2}, 32'h00);
        en = 1'b1;
        tick();
        check_frame(1, 32'hB6B6B6B6, 32'hB6B6B6B6, "en_resume");

        // Blink on the lower group only
        pulse_load(32'h76543210, 8'h00, 8'h00, 8'h0F);
        wait_ack("blink");
        e1 = 32'hF2DA60FC;
        for (int j = 0; j < 64; j++) begin
            s  = (j / 4) % 4;
            et = (j % 4 == 0) ? 8'h00 : (8'h11 << s);
`ifdef SEG_BLINK_EN
            on = (((edges - 1) / 16) % 2) == 0;
`else
            on = 1'b1;
`endif
            e1b = on ? e1[8*s +: 8] : 8'h00;
            check($sformatf("blink_j%0d_tube", j), {24'b0, tube_sel}, {24'b0, et});
            check($sformatf("blink_j%0d_d1", j), {24'b0, digit1}, {24'b0, e1b});
            check($sformatf("blink_j%0d_d2", j), {24'b0, digit2},
                  {24'b0, (s == 0) ? 8'h66 : (s == 1) ? 8'hB6 : (s == 2) ? 8'hBE : 8'hE0});
            tick();
        end

        // Reset during slot 2 with a frame pending
        pulse_load(32'h99999999, 8'h00, 8'h00, 8'h00);
        repeat (8) tick();
        #2 rst = 1'b0;
        #1;
        check("rstmid_tube", {24'b0, tube_sel}, 32'h00);
        check("rstmid_d1", {24'b0, digit1}, 32'h00);
        check("rstmid_d2", {24'b0, digit2}, 32'h00);
        check("rstmid_ack", {31'b0, load_ack}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        drive(32'h0, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            tick();
            c  = (k - 1) % 4;
            s  = ((k - 1) / 4) % 4;
            et = (c == 0) ? 8'h00 : (8'h11 << s);
            check($sformatf("rstpost_k%0d_tube", k), {24'b0, tube_sel}, {24'b0, et});
            check($sformatf("rstpost_k%0d_d1", k), {24'b0, digit1}, 32'hFC);
            check($sformatf("rstpost_k%0d_d2", k), {24'b0, digit2}, 32'hFC);
            check($sformatf("rstpost_k%0d_ack", k), {31'b0, load_ack}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
